// File: rtl/turn_scheduler.sv
// turn_scheduler: two-player timed shooting game controller.
//   Parameters: PREP_SEC (pre-turn countdown start value), TURN_D1/TURN_D0
//   (BCD turn time start value), ROUNDS (turns per player).
//   Ports:
//     clk, rst (async, active low)
//     start, goal, tick - one-cycle pulses (tick is the 1 Hz enable)
//     dig3..dig0        - display codes (0-9 digit, 10 dash, 11 blank)
//     player            - active player (0 = P1, 1 = P2)
//     winner            - 0 none, 1 P1, 2 P2, 3 tie
//     done              - one-cycle pulse on entry to FINISH
//
// state  | meaning
// IDLE   | waiting for start after reset
// PREP   | pre-turn countdown shown, prep decrements on tick
// PLAY   | turn running, BCD timer counts down, goals scored
// FINISH | game over, winner latched, waiting for a new start
module turn_scheduler #(
  parameter int unsigned PREP_SEC = 3,
  parameter int unsigned TURN_D1  = 3,
  parameter int unsigned TURN_D0  = 0,
  parameter int unsigned ROUNDS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       goal,
  input  logic       tick,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       player,
  output logic [1:0] winner,
  output logic       done
);

  localparam logic [3:0] PREP_V   = 4'(PREP_SEC);
  localparam logic [7:0] TURN_V   = {4'(TURN_D1), 4'(TURN_D0)};
  localparam logic [3:0] ROUNDS_V = 4'(ROUNDS);
  localparam logic [3:0] DASH     = 4'd10;
  localparam logic [3:0] BLANK    = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [7:0] score1, score1_n;
  logic [7:0] score2, score2_n;
  logic [7:0] timer, timer_n;
  logic [3:0] prep, prep_n;
  logic [3:0] round, round_n;
  logic       player_n;
  logic [1:0] winner_n;
  logic       done_n;
  logic [7:0] shown_score;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Two-digit BCD decrement; only called with a non-zero value.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      score1 <= 8'h00;
      score2 <= 8'h00;
      timer  <= 8'h00;
      prep   <= 4'd0;
      round  <= 4'd1;
      player <= 1'b0;
      winner <= 2'd0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      score1 <= score1_n;
      score2 <= score2_n;
      timer  <= timer_n;
      prep   <= prep_n;
      round  <= round_n;
      player <= player_n;
      winner <= winner_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    score1_n = score1;
    score2_n = score2;
    timer_n  = timer;
    prep_n   = prep;
    round_n  = round;
    player_n = player;
    winner_n = winner;
    done_n   = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          score1_n = 8'h00;
          score2_n = 8'h00;
          round_n  = 4'd1;
          player_n = 1'b0;
          prep_n   = PREP_V;
          winner_n = 2'd0;
          state_n  = PREP;
        end
      end
      PREP: begin
        if (tick) begin
          if (prep == 4'd0) begin
            timer_n = TURN_V;
            state_n = PLAY;
          end else begin
            prep_n = prep - 4'd1;
          end
        end
      end
      PLAY: begin
        // The goal is applied first so a goal coinciding with turn end is
        // credited to the outgoing player and included in the final compare.
        if (goal) begin
          if (player) score2_n = bcd_inc(score2);
          else        score1_n = bcd_inc(score1);
        end
        if (tick) begin
          if (timer != 8'h00) begin
            timer_n = bcd_dec(timer);
          end else if (!player) begin
            player_n = 1'b1;
            prep_n   = PREP_V;
            state_n  = PREP;
          end else if (round < ROUNDS_V) begin
            round_n  = round + 4'd1;
            player_n = 1'b0;
            prep_n   = PREP_V;
            state_n  = PREP;
          end else begin
            state_n = FINISH;
            done_n  = 1'b1;
            // Valid BCD orders the same as binary, so a plain compare works.
            if (score1_n > score2_n)      winner_n = 2'd1;
            else if (score2_n > score1_n) winner_n = 2'd2;
            else                          winner_n = 2'd3;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dig3 = DASH;
    dig2 = DASH;
    dig1 = DASH;
    dig0 = DASH;
    shown_score = 8'h00;
    case (state)
      PREP: begin
        dig3 = {3'b000, player} + 4'd1;
        dig2 = DASH;
        dig1 = BLANK;
        dig0 = prep;
      end
      PLAY: begin
        shown_score = player ? score2 : score1;
        dig3 = timer[7:4];
        dig2 = timer[3:0];
        dig1 = shown_score[7:4];
        dig0 = shown_score[3:0];
      end
      FINISH: begin
        shown_score = (winner == 2'd2) ? score2 : score1;
        dig3 = {2'b00, winner};
        dig2 = DASH;
        dig1 = shown_score[7:4];
        dig0 = shown_score[3:0];
      end
      default: begin
        dig3 = DASH;
        dig2 = DASH;
        dig1 = DASH;
        dig0 = DASH;
      end
    endcase
  end

endmodule
